// File: rtl/donghoso_pkg.sv
// Shared types and constants for the digital-clock time base.
package donghoso_pkg;

  // Value of each state is the field_sel code presented to the display driver.
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StSetHh = 2'd1,
    StSetMm = 2'd2,
    StSetSs = 2'd3
  } state_e;

  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  // btn_mode walks RUN -> HH -> MM -> SS -> RUN.
  function automatic state_e next_field(input state_e s);
    case (s)
      StRun:   return StSetHh;
      StSetHh: return StSetMm;
      StSetMm: return StSetSs;
      default: return StRun;
    endcase
  endfunction

endpackage

// File: rtl/timekeeper_ctrl_if.sv
// Tick/button inputs and time/display outputs of the timekeeper controller.
interface timekeeper_ctrl_if;
  import donghoso_pkg::*;

  logic              tick_1hz;
  logic              btn_mode;
  logic              btn_inc;
  logic [HOUR_W-1:0] hours;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  logic [1:0]        field_sel;
  logic              blink;
  logic              day_pulse;

  // master: divider/buttons side and display consumer; slave: the controller.
  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  hours, minutes, seconds, field_sel, blink, day_pulse
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output hours, minutes, seconds, field_sel, blink, day_pulse
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the inc that rolls over.
module mod_counter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MAX   = 59
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  logic [WIDTH-1:0] value_q, value_d;

  assign wrap  = inc && (value_q == WIDTH'(MAX));
  assign value = value_q;

  // Next value: clear dominates, otherwise step and roll over at MAX.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = wrap ? '0 : value_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/timekeeper_ctrl.sv
// hh:mm:ss time base with a set-mode FSM, blink and set-mode timeout.
module timekeeper_ctrl
  import donghoso_pkg::*;
#(
  parameter int unsigned HOUR_MAX    = 23,
  parameter int unsigned SET_TIMEOUT = 30
) (
  input logic              clk,
  input logic              reset_n,
  timekeeper_ctrl_if.slave bus
);

  localparam int unsigned TO_W = (SET_TIMEOUT > 1) ? $clog2(SET_TIMEOUT + 1) : 1;

  state_e          state_q, state_d;
  logic            blink_q, blink_d;
  logic            day_q, day_d;
  logic [TO_W-1:0] to_q, to_d;

  logic              in_run, btn_any, to_expire;
  logic              sec_inc, sec_clr, min_inc, hour_inc;
  logic              sec_wrap, min_wrap, hour_wrap;
  logic [HOUR_W-1:0] hours_val;
  logic [MIN_W-1:0]  min_val;
  logic [SEC_W-1:0]  sec_val;

  assign in_run  = (state_q == StRun);
  assign btn_any = bus.btn_mode || bus.btn_inc;

  // Carries ripple only in RUN; in set states btn_inc drives the selected field alone.
  assign sec_inc  = in_run && bus.tick_1hz;
  assign sec_clr  = (state_q == StSetSs) && bus.btn_inc;
  assign min_inc  = in_run ? sec_wrap : ((state_q == StSetMm) && bus.btn_inc);
  assign hour_inc = in_run ? min_wrap : ((state_q == StSetHh) && bus.btn_inc);

  // A button pulse restarts the timeout, so it also suppresses expiry on that cycle.
  assign to_expire = (SET_TIMEOUT != 0) && !in_run && !btn_any && bus.tick_1hz &&
                     (to_q == TO_W'(SET_TIMEOUT - 1));

  mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (sec_inc),
    .clr     (sec_clr),
    .value   (sec_val),
    .wrap    (sec_wrap)
  );

  mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (min_inc),
    .clr     (1'b0),
    .value   (min_val),
    .wrap    (min_wrap)
  );

  mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hour_inc),
    .clr     (1'b0),
    .value   (hours_val),
    .wrap    (hour_wrap)
  );

  // Next state, timeout counter, blink and day pulse.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    if (bus.btn_mode) begin
      state_d = next_field(state_q);
    end else if (to_expire) begin
      state_d = StRun;
    end

    if (in_run || btn_any || to_expire) begin
      to_d = '0;
    end else if (bus.tick_1hz) begin
      to_d = to_q + TO_W'(1);
    end

    // Toggle only on ticks seen in a set state; anything landing in RUN shows solid.
    blink_d = (state_d == StRun) ? 1'b0 : (blink_q ^ (!in_run && bus.tick_1hz));
    day_d   = in_run && hour_wrap;
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
      to_q    <= '0;
      blink_q <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      blink_q <= blink_d;
      day_q   <= day_d;
    end
  end

  assign bus.hours     = hours_val;
  assign bus.minutes   = min_val;
  assign bus.seconds   = sec_val;
  assign bus.field_sel = state_q;
  assign bus.blink     = blink_q;
  assign bus.day_pulse = day_q;

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Directed bench for timekeeper_ctrl: vector table plus hand sequences.
module tb_timekeeper_ctrl;
  import donghoso_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  timekeeper_ctrl_if bus();

  timekeeper_ctrl #(.HOUR_MAX(23), .SET_TIMEOUT(30)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic day_seen;

  typedef struct {
    logic tick, mode, inc;
    int   h, m, s, f, b, d;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hours"},   32'(bus.hours),   32'(h));
    check({tag, ".minutes"}, 32'(bus.minutes), 32'(m));
    check({tag, ".seconds"}, 32'(bus.seconds), 32'(s));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic t, input logic m, input logic i);
    bus.tick_1hz = t;
    bus.btn_mode = m;
    bus.btn_inc  = i;
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    if (bus.day_pulse === 1'b1) day_seen = 1'b1;
  endtask

  task automatic repeat_step(input int n, input logic t, input logic i);
    for (int k = 0; k < n; k++) step(t, 1'b0, i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    // Starts at 00:01:10 in RUN.
    vecs[0]  = '{1, 1, 0, 0, 1, 11, 1, 0, 0};  // tick+mode: tick applied, then SET_HH
    vecs[1]  = '{0, 0, 1, 1, 1, 11, 1, 0, 0};
    vecs[2]  = '{0, 0, 1, 2, 1, 11, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 3, 1, 11, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 4, 1, 11, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 5, 1, 11, 1, 0, 0};
    vecs[6]  = '{1, 0, 0, 5, 1, 11, 1, 1, 0};  // ticks only toggle blink
    vecs[7]  = '{1, 0, 0, 5, 1, 11, 1, 0, 0};
    vecs[8]  = '{1, 0, 0, 5, 1, 11, 1, 1, 0};
    vecs[9]  = '{0, 1, 1, 6, 1, 11, 2, 1, 0};  // inc on HH, then advance
    vecs[10] = '{0, 0, 1, 6, 2, 11, 2, 1, 0};
    vecs[11] = '{1, 0, 1, 6, 3, 11, 2, 0, 0};
    vecs[12] = '{0, 1, 0, 6, 3, 11, 3, 0, 0};
    vecs[13] = '{0, 0, 1, 6, 3, 0, 3, 0, 0};   // inc in SET_SS clears seconds
    vecs[14] = '{1, 0, 0, 6, 3, 0, 3, 1, 0};
    vecs[15] = '{0, 0, 1, 6, 3, 0, 3, 1, 0};
    vecs[16] = '{0, 1, 0, 6, 3, 0, 0, 0, 0};   // back to RUN, blink forced off
    vecs[17] = '{0, 0, 1, 6, 3, 0, 0, 0, 0};   // inc ignored in RUN
    vecs[18] = '{1, 0, 0, 6, 3, 1, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 6, 3, 1, 0, 0, 0};

    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    day_seen     = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_time("reset", 0, 0, 0);
    check("reset.field_sel", 32'(bus.field_sel), 32'd0);
    check("reset.blink",     32'(bus.blink),     32'd0);
    check("reset.day_pulse", 32'(bus.day_pulse), 32'd0);
    reset_n = 1'b1;

    // 61 ticks carry seconds into minutes.
    repeat_step(61, 1'b1, 1'b0);
    check_time("run61", 0, 1, 1);
    check("run61.day_seen", 32'(day_seen), 32'd0);
    repeat_step(9, 1'b1, 1'b0);
    check("run70.seconds", 32'(bus.seconds), 32'd10);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].tick, vecs[i].mode, vecs[i].inc);
      check_time($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].s);
      check($sformatf("vec%0d.field_sel", i), 32'(bus.field_sel), 32'(vecs[i].f));
      check($sformatf("vec%0d.blink", i),     32'(bus.blink),     32'(vecs[i].b));
      check($sformatf("vec%0d.day_pulse", i), 32'(bus.day_pulse), 32'(vecs[i].d));
    end

    // Set 23:59 via the FSM, with an hour wrap that must not carry.
    step(1'b0, 1'b1, 1'b0);
    repeat_step(17, 1'b0, 1'b1);
    check("sethh.hours23", 32'(bus.hours), 32'd23);
    step(1'b0, 1'b0, 1'b1);
    check_time("sethh.wrap", 0, 3, 1);
    repeat_step(23, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(56, 1'b0, 1'b1);
    check("setmm.minutes59", 32'(bus.minutes), 32'd59);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check_time("set.done", 23, 59, 0);
    check("set.done.field_sel", 32'(bus.field_sel), 32'd0);

    // Day rollover.
    day_seen = 1'b0;
    repeat_step(58, 1'b1, 1'b0);
    check_time("pre_day", 23, 59, 58);
    check("pre_day.day_seen", 32'(day_seen), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("day59.day_pulse", 32'(bus.day_pulse), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check_time("day", 0, 0, 0);
    check("day.day_pulse", 32'(bus.day_pulse), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("day_after.day_pulse", 32'(bus.day_pulse), 32'd0);

    // Minute wrap in SET_MM, then asynchronous reset mid-set.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("mm.field_sel", 32'(bus.field_sel), 32'd2);
    repeat_step(59, 1'b0, 1'b1);
    check("mm.minutes59", 32'(bus.minutes), 32'd59);
    step(1'b0, 1'b0, 1'b1);
    check_time("mm.wrap", 0, 0, 0);
    repeat_step(5, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("mm.minutes5", 32'(bus.minutes), 32'd5);
    check("mm.blink", 32'(bus.blink), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_time("async_rst", 0, 0, 0);
    check("async_rst.field_sel", 32'(bus.field_sel), 32'd0);
    check("async_rst.blink",     32'(bus.blink),     32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("post_rst.seconds", 32'(bus.seconds), 32'd1);
    check("post_rst.field_sel", 32'(bus.field_sel), 32'd0);

    // Timeout from SET_MM after 30 idle ticks.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(29, 1'b1, 1'b0);
    check("to29.field_sel", 32'(bus.field_sel), 32'd2);
    check("to29.blink",     32'(bus.blink),     32'd1);
    step(1'b1, 1'b0, 1'b0);
    check("to30.field_sel", 32'(bus.field_sel), 32'd0);
    check("to30.blink",     32'(bus.blink),     32'd0);
    check("to30.seconds",   32'(bus.seconds),   32'd1);
    step(1'b1, 1'b0, 1'b0);
    check("resume.seconds", 32'(bus.seconds), 32'd2);

    // btn_mode beats a same-cycle expiry and restarts the count.
    step(1'b0, 1'b1, 1'b0);
    repeat_step(29, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("mode_win.field_sel", 32'(bus.field_sel), 32'd2);
    check("mode_win.blink",     32'(bus.blink),     32'd0);
    repeat_step(29, 1'b1, 1'b0);
    check("restart29.field_sel", 32'(bus.field_sel), 32'd2);
    step(1'b1, 1'b0, 1'b0);
    check("restart30.field_sel", 32'(bus.field_sel), 32'd0);
    check_time("restart30", 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
